// File: rtl/spi_bridge_pkg.sv
// spi_bridge_pkg: shared state type and command-entry layout for the SPI master sequencer.
package spi_bridge_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_POP, S_LOAD, S_WAIT_RSP, S_SETUP, S_SHIFT, S_HOLD, S_PUSH, S_GAP
    } seq_state_t;
    localparam int CMD_RW_BIT   = 16;
    localparam int CMD_ADDR_MSB = 15;
    localparam int CMD_ADDR_LSB = 8;
    localparam int CMD_DATA_MSB = 7;
    localparam int CMD_DATA_LSB = 0;
    localparam int FRAME_BITS   = 16;
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: SCLK half-period divider with single-cycle rise/fall strobes.
module spi_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic run_i,
    output logic sclk_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);
    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);
    logic [7:0] cnt_q;
    logic sclk_q;
    logic tick;
    assign tick        = run_i && cnt_q == LAST;
    assign rise_tick_o = tick && !sclk_q;
    assign fall_tick_o = tick && sclk_q;
    assign sclk_o      = sclk_q;
    // Idle counter is preloaded so the first run cycle already produces the rising edge.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || !run_i) begin
            cnt_q  <= LAST;
            sclk_q <= 1'b0;
        end else if (tick) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end
endmodule

// File: rtl/spi_master_sequencer.sv
// spi_master_sequencer: pops command entries, runs SPI mode-0 frames, pushes read responses.
module spi_master_sequencer
    import spi_bridge_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int IDLE_GAP = 2
) (
    input  logic             PCLK,
    input  logic             PRESET_N,
    input  logic             enable,
    input  logic             w_empty,
    input  logic             w_valid,
    input  logic [2*WIDTH:0] w_dout,
    input  logic             w_rd_rst_busy,
    output logic             w_rd_en,
    input  logic             r_full,
    input  logic             r_wr_rst_busy,
    output logic             r_wr_en,
    output logic [WIDTH-1:0] r_din,
    output logic             SCLK,
    output logic             MOSI,
    input  logic             MISO,
    output logic             CS_n,
    output logic             busy,
    output logic [15:0]      txn_count
);
    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] SHIFT_LAST = 16'(FRAME_BITS * 2 * CLK_DIV - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
    localparam logic [15:0] GAP_LAST   = 16'(IDLE_GAP - 1);

    seq_state_t            state_q;
    logic [15:0]           cnt_q;
    logic [FRAME_BITS-1:0] sr_q;
    logic [WIDTH-1:0]      cap_q;
    logic [WIDTH-1:0]      r_din_q;
    logic [15:0]           txn_q;
    logic rw_q, cs_n_q, mosi_q, w_rd_en_q, r_wr_en_q, busy_q;
    logic go, run, rise_tick, fall_tick;

    assign go  = enable && !w_empty && !w_rd_rst_busy && !r_wr_rst_busy;
    // The divider starts one cycle early so SCLK is already high in the first SHIFT cycle.
    assign run = (state_q == S_SETUP && cnt_q == SETUP_LAST) ||
                 (state_q == S_SHIFT && cnt_q != SHIFT_LAST);

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk (
        .clk_i      (PCLK),
        .rst_n_i    (PRESET_N),
        .run_i      (run),
        .sclk_o     (SCLK),
        .rise_tick_o(rise_tick),
        .fall_tick_o(fall_tick)
    );

    always_ff @(posedge PCLK) begin
        if (!PRESET_N) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            cap_q     <= '0;
            r_din_q   <= '0;
            txn_q     <= '0;
            rw_q      <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            w_rd_en_q <= 1'b0;
            r_wr_en_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            w_rd_en_q <= 1'b0;
            r_wr_en_q <= 1'b0;
            cnt_q     <= cnt_q + 16'd1;
            if (rise_tick) cap_q <= {cap_q[WIDTH-2:0], MISO};
            if (fall_tick) begin
                sr_q   <= sr_q << 1;
                mosi_q <= sr_q[FRAME_BITS-2];
            end
            case (state_q)
                S_IDLE: if (go) begin
                    state_q   <= S_POP;
                    w_rd_en_q <= 1'b1;
                    busy_q    <= 1'b1;
                end
                S_POP: state_q <= S_LOAD;
                S_LOAD: if (w_valid) begin
                    rw_q <= w_dout[CMD_RW_BIT];
                    sr_q <= {w_dout[CMD_ADDR_MSB:CMD_ADDR_LSB],
                             w_dout[CMD_DATA_MSB:CMD_DATA_LSB] & {WIDTH{w_dout[CMD_RW_BIT]}}};
                    if (!w_dout[CMD_RW_BIT] && r_full) begin
                        state_q <= S_WAIT_RSP;
                    end else begin
                        state_q <= S_SETUP;
                        cs_n_q  <= 1'b0;
                        mosi_q  <= w_dout[CMD_ADDR_MSB];
                        cnt_q   <= '0;
                    end
                end
                S_WAIT_RSP: if (!r_full) begin
                    state_q <= S_SETUP;
                    cs_n_q  <= 1'b0;
                    mosi_q  <= sr_q[FRAME_BITS-1];
                    cnt_q   <= '0;
                end
                S_SETUP: if (cnt_q == SETUP_LAST) begin
                    state_q <= S_SHIFT;
                    cnt_q   <= '0;
                end
                S_SHIFT: if (cnt_q == SHIFT_LAST) begin
                    state_q <= S_HOLD;
                    cnt_q   <= '0;
                end
                S_HOLD: if (cnt_q == HOLD_LAST) begin
                    cs_n_q <= 1'b1;
                    cnt_q  <= '0;
                    if (rw_q) begin
                        state_q <= S_GAP;
                        txn_q   <= txn_q + 16'd1;
                    end else begin
                        state_q   <= S_PUSH;
                        r_wr_en_q <= 1'b1;
                        r_din_q   <= cap_q;
                    end
                end
                S_PUSH: begin
                    state_q <= S_GAP;
                    txn_q   <= txn_q + 16'd1;
                    cnt_q   <= '0;
                end
                S_GAP: if (cnt_q == GAP_LAST) begin
                    if (go) begin
                        state_q   <= S_POP;
                        w_rd_en_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign w_rd_en   = w_rd_en_q;
    assign r_wr_en   = r_wr_en_q;
    assign r_din     = r_din_q;
    assign MOSI      = mosi_q;
    assign CS_n      = cs_n_q;
    assign busy      = busy_q;
    assign txn_count = txn_q;
endmodule
